// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and encodings for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Round-robin pointer values: which source wins when both request.
  localparam logic RR_ALU = 1'b0;
  localparam logic RR_LSU = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational grant, registered priority pointer.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       rr_ptr
);

  logic r_ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (r_ptr == RR_LSU) ? 2'b10 : 2'b01;
    end
  end

  // After any grant the other source gets priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= RR_ALU;
    end else if (advance) begin
      r_ptr <= gnt[0] ? RR_LSU : RR_ALU;
    end
  end

  assign rr_ptr = r_ptr;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file write port: clears x1..x(N-1) after reset, then
// arbitrates ALU and LSU writebacks onto the single registered WE3/A3/WD3.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN           = DEF_XLEN,
  parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  output logic                  we3,
  output logic [REG_ADDR_W-1:0] a3,
  output logic [XLEN-1:0]       wd3,
  output logic                  init_done,
  output state_t                dbg_state,
  output logic                  dbg_rr_ptr
);

  localparam logic [REG_ADDR_W-1:0] LAST_REG    = {REG_ADDR_W{1'b1}};
  localparam state_t                RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t                r_state, w_state_nxt;
  logic [REG_ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic                  r_we3, w_we3_nxt;
  logic [REG_ADDR_W-1:0] r_a3, w_a3_nxt;
  logic [XLEN-1:0]       r_wd3, w_wd3_nxt;
  logic [1:0]            w_req;
  logic [1:0]            w_gnt;

  // Handshake: a payload is accepted at the posedge where valid && ready.
  // Ready is combinational, never asserted without its own valid, and held
  // low during the clear sweep so requests simply wait for RUN.
  assign w_req = (r_state == ST_RUN) ? {lsu_valid, alu_valid} : 2'b00;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (|w_gnt),
    .gnt     (w_gnt),
    .rr_ptr  (dbg_rr_ptr)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_we3_nxt     = 1'b0;
    w_a3_nxt      = r_a3;
    w_wd3_nxt     = r_wd3;
    case (r_state)
      ST_CLEAR: begin
        w_we3_nxt     = 1'b1;
        w_a3_nxt      = r_clr_cnt;
        w_wd3_nxt     = '0;
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == LAST_REG) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // A write to x0 still completes the handshake but is never issued.
        if (w_gnt[0]) begin
          w_we3_nxt = |alu_rd;
          w_a3_nxt  = alu_rd;
          w_wd3_nxt = alu_data;
        end else if (w_gnt[1]) begin
          w_we3_nxt = |lsu_rd;
          w_a3_nxt  = lsu_rd;
          w_wd3_nxt = lsu_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RESET_STATE;
      r_clr_cnt <= {{(REG_ADDR_W-1){1'b0}}, 1'b1};
      r_we3     <= 1'b0;
      r_a3      <= '0;
      r_wd3     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_we3     <= w_we3_nxt;
      r_a3      <= w_a3_nxt;
      r_wd3     <= w_wd3_nxt;
    end
  end

  assign alu_ready = w_gnt[0];
  assign lsu_ready = w_gnt[1];
  assign we3       = r_we3;
  assign a3        = r_a3;
  assign wd3       = r_wd3;
  assign init_done = (r_state == ST_RUN);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter with a behavioural register file on its write port.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #10 clk = ~clk;

  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        alu_ready, lsu_ready, we3, init_done, dbg_rr_ptr;
  logic [4:0]  a3;
  logic [31:0] wd3;
  state_t      dbg_state;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .we3(we3), .a3(a3), .wd3(wd3), .init_done(init_done),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // Register file without reset; rf_scramble fills it with junk so the sweep matters.
  logic [31:0] rf_mem [32];
  logic        rf_scramble = 1'b0;
  always @(posedge clk) begin
    if (rf_scramble) begin
      for (int k = 0; k < 32; k++) rf_mem[k] <= (k == 0) ? 32'h0 : (32'hBAD0_0000 | k);
    end else if (we3) begin
      rf_mem[a3] <= wd3;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] model_rf [32];
  logic        model_pref;      // 0: ALU wins a tie, 1: LSU wins a tie
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd3;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic lv; logic [4:0] lr; logic [31:0] ld;
    logic e_ar; logic e_lr; logic e_we; logic [4:0] e_a3; logic [31:0] e_wd;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive one cycle, check readies, then the registered write.
  task automatic drive_check(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                             input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                             input logic e_ar, input logic e_lr, input logic e_we,
                             input logic [4:0] e_a3, input logic [31:0] e_wd);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
    #1;
    check("alu_ready", 64'(alu_ready), 64'(e_ar));
    check("lsu_ready", 64'(lsu_ready), 64'(e_lr));
    check("init_done_run", 64'(init_done), 64'd1);
    @(negedge clk);
    check("we3", 64'(we3), 64'(e_we));
    check("a3", 64'(a3), 64'(e_a3));
    check("wd3", 64'(wd3), 64'(e_wd));
    if (e_ar) begin
      model_pref = 1'b1;
      if (ar != 5'd0) model_rf[ar] = ad;
    end else if (e_lr) begin
      model_pref = 1'b0;
      if (lr != 5'd0) model_rf[lr] = ld;
    end
    exp_a3  = e_a3;
    exp_wd3 = e_wd;
    check("rr_ptr", 64'(dbg_rr_ptr), 64'(model_pref));
  endtask

  // Expected outcome derived from the arbitration rules, then applied.
  task automatic model_step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                            input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                            output logic g_a, output logic g_l);
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    g_a  = av && (!lv || model_pref == 1'b0);
    g_l  = lv && !g_a;
    e_we = (g_a && ar != 5'd0) || (g_l && lr != 5'd0);
    e_a3 = g_a ? ar : (g_l ? lr : exp_a3);
    e_wd = g_a ? ad : (g_l ? ld : exp_wd3);
    drive_check(av, ar, ad, lv, lr, ld, g_a, g_l, e_we, e_a3, e_wd);
  endtask

  // Starts at the negedge where rst was released; ends at a negedge in RUN.
  task automatic sweep();
    for (int i = 1; i < 32; i++) begin
      #1;
      check("clr_alu_ready", 64'(alu_ready), 64'd0);
      check("clr_lsu_ready", 64'(lsu_ready), 64'd0);
      check("clr_init_done", 64'(init_done), 64'd0);
      @(negedge clk);
      check("clr_we3", 64'(we3), 64'd1);
      check("clr_a3", 64'(a3), 64'(i));
      check("clr_wd3", 64'(wd3), 64'd0);
    end
    check("sweep_init_done", 64'(init_done), 64'd1);
    check("sweep_state", 64'(dbg_state), 64'(ST_RUN));
    model_pref = 1'b0;
    exp_a3     = 5'd31;
    exp_wd3    = 32'h0;
    for (int k = 0; k < 32; k++) model_rf[k] = 32'h0;
  endtask

  // One idle cycle lets the last write commit, then every register is compared.
  task automatic check_rf();
    logic ga, gl;
    model_step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ga, gl);
    for (int k = 0; k < 32; k++) check($sformatf("rf_x%0d", k), 64'(rf_mem[k]), 64'(model_rf[k]));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        ga, gl, a_pend, l_pend;
  logic [4:0]  r_ar, r_lr;
  logic [31:0] r_ad, r_ld;

  initial begin
    tbl[0] = '{1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b1, 1'b0, 1'b1, 5'd1, 32'hA};
    tbl[1] = '{1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b0, 1'b1, 1'b1, 5'd2, 32'hB};
    tbl[2] = '{1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b1, 1'b0, 1'b1, 5'd1, 32'hA};
    tbl[3] = '{1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b0, 1'b1, 1'b1, 5'd2, 32'hB};
    tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd2, 32'hB};
    tbl[5] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234};
    tbl[7] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    tbl[8] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99};
    tbl[9] = '{1'b1, 5'd10, 32'h1010, 1'b1, 5'd11, 32'h1111, 1'b1, 1'b0, 1'b1, 5'd10, 32'h1010};

    // Reset values, then the clear sweep with no requests.
    #2 rst = 1'b1; rf_scramble = 1'b1;
    #3;
    check("rst_we3", 64'(we3), 64'd0);
    check("rst_a3", 64'(a3), 64'd0);
    check("rst_wd3", 64'(wd3), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
    repeat (2) @(negedge clk);
    rf_scramble = 1'b0;
    rst = 1'b0;
    sweep();
    check_rf();

    // Directed vectors: alternation, single requester, x0 drop, pointer after x0.
    for (int v = 0; v < 10; v++) begin
      drive_check(tbl[v].av, tbl[v].ar, tbl[v].ad, tbl[v].lv, tbl[v].lr, tbl[v].ld,
                  tbl[v].e_ar, tbl[v].e_lr, tbl[v].e_we, tbl[v].e_a3, tbl[v].e_wd);
    end
    check_rf();

    // Reset pulse mid-stream with both sources requesting through the sweep.
    model_step(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, ga, gl);
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB;
    #1;
    check("midrst_we3", 64'(we3), 64'd0);
    check("midrst_init_done", 64'(init_done), 64'd0);
    check("midrst_alu_ready", 64'(alu_ready), 64'd0);
    check("midrst_a3", 64'(a3), 64'd0);
    rf_scramble = 1'b1;
    @(negedge clk);
    rf_scramble = 1'b0;
    rst = 1'b0;
    sweep();
    model_step(1'b1, 5'd7, 32'h77, 1'b1, 5'd2, 32'hB, ga, gl);
    check("first_run_alu_grant", 64'(ga), 64'd1);
    model_step(1'b0, 5'd7, 32'h77, 1'b1, 5'd2, 32'hB, ga, gl);
    check_rf();

    // Random traffic obeying the requester rules.
    a_pend = 1'b0; l_pend = 1'b0;
    r_ar = '0; r_lr = '0; r_ad = '0; r_ld = '0;
    for (int c = 0; c < 320; c++) begin
      if (c < 300) begin
        if (!a_pend && $urandom_range(0, 99) < 60) begin
          a_pend = 1'b1; r_ar = 5'($urandom_range(0, 31)); r_ad = $urandom;
        end
        if (!l_pend && $urandom_range(0, 99) < 60) begin
          l_pend = 1'b1; r_lr = 5'($urandom_range(0, 31)); r_ld = $urandom;
        end
      end
      model_step(a_pend, r_ar, r_ad, l_pend, r_lr, r_ld, ga, gl);
      if (ga) a_pend = 1'b0;
      if (gl) l_pend = 1'b0;
    end
    check("random_drained", 64'({a_pend, l_pend}), 64'd0);
    check_rf();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
